// File: rtl/pipe_ctrl.sv
// Pipeline control: merges stage stall requests and exception flush into the shared stall/flush bus.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
   parameter logic [31:0]          EXC_VECTOR = 32'h0000_0020,
   parameter int                   WDT_WIDTH  = 16,
   parameter logic [WDT_WIDTH-1:0] WDT_LIMIT  = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_from_if_i,
   input  logic        stallreq_from_id_i,
   input  logic        stallreq_from_ex_i,
   input  logic        stallreq_from_mem_i,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] cp0_epc_i,
   output logic [5:0]  stall_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o,
   output logic        wdt_timeout_o,
   output logic [31:0] perf_stall_cycles_o,
   output logic [31:0] perf_flush_count_o
);

   localparam logic [31:0]          ERET_CODE = 32'h0000_000e;
   localparam logic [WDT_WIDTH-1:0] WDT_LAST  = WDT_LIMIT - WDT_WIDTH'(1);

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t               state_reg;
   state_t               state_next;
   logic [2:0]           stall_depth;
   logic                 exc_take;
   logic                 stalled;
   logic                 wdt_hit;
   logic [WDT_WIDTH-1:0] wdt_reg;
   logic [WDT_WIDTH-1:0] wdt_next;

   // A pending exception waits behind a data-bus stall so the faulting access completes first.
   assign exc_take = !rst && (state_reg == RUN) && (excepttype_i != 32'h0) && !stallreq_from_mem_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= RUN;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         RUN:     if (exc_take) state_next = FLUSH;
         FLUSH:   state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   // Stall depth n freezes stages 0..n-1; the deepest requesting stage wins.
   always_comb begin
      stall_depth = 3'd0;
      flush_o     = 1'b0;
      new_pc_o    = 32'h0;
      if (!rst && state_reg == RUN) begin
         if (exc_take) begin
            flush_o  = 1'b1;
            new_pc_o = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
         end else if (stallreq_from_mem_i) begin
            stall_depth = 3'd5;
         end else if (stallreq_from_ex_i) begin
            stall_depth = 3'd4;
         end else if (stallreq_from_id_i) begin
            stall_depth = 3'd3;
         end else if (stallreq_from_if_i) begin
            stall_depth = 3'd2;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < 6; gi++) begin : g_stall
         assign stall_o[gi] = (stall_depth > 3'(gi));
      end
   endgenerate

   assign stalled       = (stall_depth != 3'd0);
   assign wdt_hit       = stalled && (wdt_reg == WDT_LAST);
   assign wdt_timeout_o = wdt_hit;

   always_comb begin
      wdt_next = wdt_reg + WDT_WIDTH'(1);
      if (!stalled || flush_o || wdt_hit) begin
         wdt_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wdt_reg <= '0;
      end else begin
         wdt_reg <= wdt_next;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall_reg;
   logic [31:0] perf_flush_reg;

   // Saturating counters; only reset clears them.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_reg <= 32'h0;
         perf_flush_reg <= 32'h0;
      end else begin
         if (stalled && perf_stall_reg != 32'hFFFF_FFFF) begin
            perf_stall_reg <= perf_stall_reg + 32'd1;
         end
         if (flush_o && perf_flush_reg != 32'hFFFF_FFFF) begin
            perf_flush_reg <= perf_flush_reg + 32'd1;
         end
      end
   end

   assign perf_stall_cycles_o = perf_stall_reg;
   assign perf_flush_count_o  = perf_flush_reg;
`else
   assign perf_stall_cycles_o = 32'h0;
   assign perf_flush_count_o  = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, exception flush/refill, eret deferral, watchdog, perf counters.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_if;
   logic        req_id;
   logic        req_ex;
   logic        req_mem;
   logic [31:0] excepttype;
   logic [31:0] cp0_epc;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        wdt_timeout;
   logic [31:0] perf_stall;
   logic [31:0] perf_flush;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   pipe_ctrl #(
      .EXC_VECTOR (32'h0000_0020),
      .WDT_WIDTH  (16),
      .WDT_LIMIT  (16'd8)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .stallreq_from_if_i  (req_if),
      .stallreq_from_id_i  (req_id),
      .stallreq_from_ex_i  (req_ex),
      .stallreq_from_mem_i (req_mem),
      .excepttype_i        (excepttype),
      .cp0_epc_i           (cp0_epc),
      .stall_o             (stall),
      .flush_o             (flush),
      .new_pc_o            (new_pc),
      .wdt_timeout_o       (wdt_timeout),
      .perf_stall_cycles_o (perf_stall),
      .perf_flush_count_o  (perf_flush)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Sample mid-cycle on the falling edge; one line per checked transaction.
   task automatic expect_cycle(input string tag, input logic [5:0] e_stall, input logic e_flush,
                               input logic [31:0] e_pc);
      @(negedge clk);
      $display("%s: stall=%b flush=%0d new_pc=%h wdt=%0d", tag, stall, flush, new_pc, wdt_timeout);
      chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
      chk({tag, ".flush"}, 32'(flush), 32'(e_flush));
      chk({tag, ".new_pc"}, new_pc, e_pc);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_reqs(input logic i_f, input logic i_d, input logic i_e, input logic i_m);
      req_if  = i_f;
      req_id  = i_d;
      req_ex  = i_e;
      req_mem = i_m;
   endtask

   logic [31:0] exp_ps;
   logic [31:0] exp_pf;

   initial begin
      // 1: reset overrides every request
      rst        = 1'b1;
      excepttype = 32'h0;
      cp0_epc    = 32'h0;
      set_reqs(1'b1, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 2; i++) begin
         expect_cycle("rst", 6'b000000, 1'b0, 32'h0);
         chk("rst.wdt", 32'(wdt_timeout), 32'h0);
         chk("rst.perf_stall", perf_stall, 32'h0);
         chk("rst.perf_flush", perf_flush, 32'h0);
         next_cycle();
      end
      rst = 1'b0;
      expect_cycle("rel_mem", 6'b011111, 1'b0, 32'h0);
      next_cycle();
      set_reqs(1'b0, 1'b0, 1'b0, 1'b0);
      expect_cycle("idle", 6'b000000, 1'b0, 32'h0);
      next_cycle();

      // 2: priority among ID/EX
      set_reqs(1'b0, 1'b1, 1'b1, 1'b0);
      expect_cycle("id_ex", 6'b001111, 1'b0, 32'h0);
      next_cycle();
      req_ex = 1'b0;
      expect_cycle("id", 6'b000111, 1'b0, 32'h0);
      next_cycle();
      req_id = 1'b0;
      expect_cycle("none", 6'b000000, 1'b0, 32'h0);
      next_cycle();
      req_if = 1'b1;
      expect_cycle("if", 6'b000011, 1'b0, 32'h0);
      next_cycle();
      req_if = 1'b0;

      // 3: exception flush, FLUSH bubble ignores requests, then normal again
      excepttype = 32'h8;
      req_id     = 1'b1;
      expect_cycle("exc8", 6'b000000, 1'b1, 32'h0000_0020);
      next_cycle();
      excepttype = 32'h0;
      expect_cycle("flush_bub", 6'b000000, 1'b0, 32'h0);
      next_cycle();
      expect_cycle("after_bub", 6'b000111, 1'b0, 32'h0);
      next_cycle();
      req_id = 1'b0;

      // 4: eret deferred behind a mem stall; FLUSH ignores the still-asserted code
      excepttype = 32'he;
      cp0_epc    = 32'h0000_1234;
      req_mem    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         expect_cycle("eret_mem", 6'b011111, 1'b0, 32'h0);
         next_cycle();
      end
      req_mem = 1'b0;
      expect_cycle("eret", 6'b000000, 1'b1, 32'h0000_1234);
      next_cycle();
      expect_cycle("eret_bub", 6'b000000, 1'b0, 32'h0);
      next_cycle();
      excepttype = 32'h0;
      expect_cycle("idle2", 6'b000000, 1'b0, 32'h0);
      next_cycle();

      // 5: watchdog with limit 8, EX held for 20 cycles
      req_ex = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         $display("wdt cycle %0d: stall=%b wdt=%0d", n, stall, wdt_timeout);
         chk($sformatf("wdt%0d.stall", n), 32'(stall), 32'h0f);
         chk($sformatf("wdt%0d.pulse", n), 32'(wdt_timeout), ((n == 8) || (n == 16)) ? 32'h1 : 32'h0);
         next_cycle();
      end
      req_ex = 1'b0;
      expect_cycle("wdt_end", 6'b000000, 1'b0, 32'h0);
      chk("wdt_end.pulse", 32'(wdt_timeout), 32'h0);
      next_cycle();

      // 6: perf counters after a fresh reset: 5 stalled cycles, 2 exceptions
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      expect_cycle("perf_clr", 6'b000000, 1'b0, 32'h0);
      chk("perf_clr.stall", perf_stall, 32'h0);
      chk("perf_clr.flush", perf_flush, 32'h0);
      next_cycle();
      req_if = 1'b1;
      for (int i = 0; i < 5; i++) begin
         expect_cycle("perf_if", 6'b000011, 1'b0, 32'h0);
         next_cycle();
      end
      req_if     = 1'b0;
      excepttype = 32'h8;
      expect_cycle("perf_exc1", 6'b000000, 1'b1, 32'h0000_0020);
      next_cycle();
      excepttype = 32'h0;
      next_cycle();
      excepttype = 32'h4;
      expect_cycle("perf_exc2", 6'b000000, 1'b1, 32'h0000_0020);
      next_cycle();
      excepttype = 32'h0;
      next_cycle();
`ifdef PIPE_CTRL_PERF_EN
      exp_ps = 32'd5;
      exp_pf = 32'd2;
`else
      exp_ps = 32'd0;
      exp_pf = 32'd0;
`endif
      @(negedge clk);
      $display("perf: stall_cycles=%0d flush_count=%0d", perf_stall, perf_flush);
      chk("perf.stall_cycles", perf_stall, exp_ps);
      chk("perf.flush_count", perf_flush, exp_pf);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
